if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the MIPS pipeline, directly upstream of the decode stage. It holds the program counter, the word-addressed instruction memory (loaded by the debug unit before execution), and the IF/ID pipeline register. Its `o_pc`/`o_instruction` pair drives the decode stage's `i_pc`/`i_instruction`. It honours stall and flush requests from the hazard and branch logic, and stops on a halt word.

## Interface
- `NB_ADDR`, 32, PC and target width
- `NB_INST`, 32, instruction word width
- `MEM_DEPTH`, 256, instruction memory depth in words (power of two)
- `i_clk` in 1: clock, rising edge
- `i_reset` in 1: asynchronous, active-high reset
- `i_start` in 1: leave IDLE and begin fetching at PC 0
- `i_wr_en` in 1: program-load write strobe (IDLE only)
- `i_wr_addr` in log2(MEM_DEPTH): program-load word address
- `i_wr_data` in NB_INST: program-load word
- `i_stall` in 1: hold PC and IF/ID register
- `i_pc_src` in 1: redirect PC to `i_target` (taken branch or jump)
- `i_target` in NB_ADDR: redirect address, byte address, word-aligned
- `o_pc` out NB_ADDR: PC+4 of the instruction in IF/ID
- `o_instruction` out NB_INST: instruction in IF/ID
- `o_valid` out 1: IF/ID holds a real instruction
- `o_halt` out 1: halt word reached; stays high until reset

## Operation
- FSM states:
  - IDLE: after reset. Accepts memory writes. PC held at 0. Outputs NOP (`32'h0`) with `o_valid`=0. `i_start`=1 moves to RUN on the next edge.
  - RUN: fetches every cycle.
  - HALTED: PC frozen, outputs NOP, `o_valid`=0, `o_halt`=1.
- Instruction memory:
  - Read is combinational at index `pc[log2(MEM_DEPTH)+1:2]`. Addresses beyond the depth wrap modulo MEM_DEPTH.
  - Writes are synchronous and occur only when state is IDLE and `i_wr_en`=1. Writes in RUN/HALTED are ignored.
- RUN, per edge, in priority order:
  - `i_pc_src`=1 (wins over `i_stall`): PC ← `i_target`. IF/ID ← NOP with `o_valid`=0, flushing the wrong-path fetch.
  - `i_stall`=1: PC, `o_pc`, `o_instruction` and `o_valid` all hold.
  - Fetched word equals HALT_WORD (`32'hFFFF_FFFF`): IF/ID ← NOP with `o_valid`=0, PC holds, state ← HALTED, `o_halt` ← 1.
  - Otherwise: IF/ID ← {mem[pc], pc+4} with `o_valid`=1, and PC ← pc+4.
- PC arithmetic: NB_ADDR-bit unsigned; `32'hFFFF_FFFC`+4 wraps to 0.
- Reset values (asynchronous, any state, mid-operation included): PC=0, `o_pc`=0, `o_instruction`=0, `o_valid`=0, `o_halt`=0, state=IDLE. Memory contents are not cleared by reset.

## Timing
- Fetch latency is 1 cycle: a PC of X at edge n produces `o_instruction`=mem[X>>2] and `o_pc`=X+4 after edge n.
- First fetch: if `i_start` is sampled at edge n, PC 0 is fetched at edge n+1 and `o_valid`=1 after edge n+1.
- Redirect: target T is fetched one edge after `i_pc_src` is sampled, so exactly one bubble is inserted.
- Halt: `o_halt` rises one cycle after the edge at which the halt word is in the fetch slot. If `i_pc_src` or `i_stall` is asserted in that same cycle, halt is not taken in that cycle.
- A write in IDLE is visible to a read on the following cycle.

## Structure
- Shared package `mips_pkg` holds:
  - NOP_INST = `32'h0`
  - HALT_WORD = `32'hFFFF_FFFF`
  - PC_STEP = 4
  - the fetch FSM state type {IDLE, RUN, HALTED}
- Sub-module `if_instruction_memory`: synchronous write port plus combinational read port, parameterized by MEM_DEPTH and NB_INST.
- PC register, FSM and IF/ID register live in `if_stage`.

## Test plan
- Load and run:
  - Stimulus: write `0x20080005` at 0 and `0x20090007` at 1, then pulse `i_start`.
  - Response: `o_instruction`=`0x20080005` with `o_pc`=4, then `0x20090007` with `o_pc`=8, and `o_valid`=1 on both.
- Stall:
  - Stimulus: assert `i_stall` for 3 cycles while the instruction at PC 8 is in IF/ID.
  - Response: outputs hold at `o_pc`=12 for 3 cycles, and the next fetch is PC 12.
- Branch redirect:
  - Stimulus: `i_pc_src`=1 with `i_target`=`0x40` and `i_stall`=1 in the same cycle.
  - Response: one NOP with `o_valid`=0, then `o_pc`=`0x44` carrying mem[16].
- Halt:
  - Stimulus: place HALT_WORD at word 3.
  - Response: after words 0–2 are output, `o_halt`=1, `o_valid`=0, PC frozen at 12, and `i_wr_en` writes are ignored.
- Halt flushed:
  - Stimulus: HALT_WORD in the fetch slot while `i_pc_src`=1.
  - Response: no halt, and fetching continues at the target.
- Reset mid-run:
  - Stimulus: assert `i_reset` between clock edges while in RUN.
  - Response: all outputs go to 0 immediately and state is IDLE. Memory still holds the program, and a new `i_start` refetches from PC 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline constants and fetch FSM state type
package mips_pkg;

    localparam logic [31:0] NOP_INST  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_instruction_memory.sv
// rtl/if_instruction_memory.sv - word-addressed instruction store
// Synchronous write port for program load, combinational read port for fetch.
module if_instruction_memory #(
    parameter int MEM_DEPTH = 256,
    parameter int NB_INST   = 32
) (
    input  logic                         i_clk,
    input  logic                         i_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_wr_addr,
    input  logic [NB_INST-1:0]           i_wr_data,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_rd_addr,
    output logic [NB_INST-1:0]           o_rd_data
);

    logic [NB_INST-1:0] mem [MEM_DEPTH];

    // Contents deliberately survive reset so a loaded program can be rerun.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, fetch FSM and IF/ID register
// Stall holds everything; a redirect flushes the wrong-path fetch with one bubble.
module if_stage
    import mips_pkg::*;
#(
    parameter int NB_ADDR   = 32,
    parameter int NB_INST   = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_wr_addr,
    input  logic [NB_INST-1:0]           i_wr_data,
    input  logic                         i_stall,
    input  logic                         i_pc_src,
    input  logic [NB_ADDR-1:0]           i_target,
    output logic [NB_ADDR-1:0]           o_pc,
    output logic [NB_INST-1:0]           o_instruction,
    output logic                         o_valid,
    output logic                         o_halt
);

    localparam int NB_MADDR = $clog2(MEM_DEPTH);

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [NB_ADDR-1:0] pc_q;
    logic [NB_ADDR-1:0] pc_d;
    logic [NB_ADDR-1:0] out_pc_d;
    logic [NB_INST-1:0] inst_d;
    logic               valid_d;
    logic               halt_d;
    logic [NB_INST-1:0] fetched;
    logic [NB_ADDR-1:0] pc_next;

    if_instruction_memory #(
        .MEM_DEPTH (MEM_DEPTH),
        .NB_INST   (NB_INST)
    ) u_imem (
        .i_clk     (i_clk),
        .i_wr_en   (i_wr_en && (state_q == IDLE)),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (pc_q[NB_MADDR+1:2]),
        .o_rd_data (fetched)
    );

    assign pc_next = pc_q + NB_ADDR'(PC_STEP);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            o_pc          <= '0;
            o_instruction <= '0;
            o_valid       <= 1'b0;
            o_halt        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            o_pc          <= out_pc_d;
            o_instruction <= inst_d;
            o_valid       <= valid_d;
            o_halt        <= halt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        out_pc_d = o_pc;
        inst_d   = o_instruction;
        valid_d  = o_valid;
        halt_d   = o_halt;

        unique case (state_q)
            IDLE: begin
                pc_d     = '0;
                out_pc_d = '0;
                inst_d   = NB_INST'(NOP_INST);
                valid_d  = 1'b0;
                halt_d   = 1'b0;
                if (i_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Redirect beats stall so a taken branch is never lost behind a hazard.
                if (i_pc_src) begin
                    pc_d     = i_target;
                    out_pc_d = '0;
                    inst_d   = NB_INST'(NOP_INST);
                    valid_d  = 1'b0;
                end else if (i_stall) begin
                    pc_d = pc_q;
                end else if (fetched == NB_INST'(HALT_WORD)) begin
                    out_pc_d = '0;
                    inst_d   = NB_INST'(NOP_INST);
                    valid_d  = 1'b0;
                    halt_d   = 1'b1;
                    state_d  = HALTED;
                end else begin
                    pc_d     = pc_next;
                    out_pc_d = pc_next;
                    inst_d   = fetched;
                    valid_d  = 1'b1;
                end
            end
            HALTED: begin
                out_pc_d = '0;
                inst_d   = NB_INST'(NOP_INST);
                valid_d  = 1'b0;
                halt_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized and directed bench for if_stage against a behavioural model
module tb_if_stage;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        stall;
    logic        pc_src;
    logic [31:0] target;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_valid;
    logic        out_halt;

    always #5 clk = ~clk;

    if_stage #(
        .NB_ADDR   (32),
        .NB_INST   (32),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .i_stall       (stall),
        .i_pc_src      (pc_src),
        .i_target      (target),
        .o_pc          (out_pc),
        .o_instruction (out_inst),
        .o_valid       (out_valid),
        .o_halt        (out_halt)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 = waiting for start, 1 = fetching, 2 = halted
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_opc;
    logic [31:0] m_inst;
    logic        m_valid;
    logic        m_halt;
    int          m_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 0; m_opc = 0; m_inst = 0; m_valid = 0; m_halt = 0; m_state = 0;
    endtask

    task automatic m_bubble();
        m_inst = 0; m_valid = 0; m_opc = 0;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        if (rst) begin
            m_reset();
        end else if (m_state == 0) begin
            if (wr_en) m_mem[wr_addr] = wr_data;
            if (start) m_state = 1;
        end else if (m_state == 1) begin
            w = m_mem[(m_pc / 4) % DEPTH];
            if (pc_src) begin
                m_pc = target;
                m_bubble();
            end else if (stall) begin
                m_pc = m_pc;
            end else if (w == 32'hFFFF_FFFF) begin
                m_bubble();
                m_state = 2;
                m_halt  = 1;
            end else begin
                m_inst  = w;
                m_opc   = m_pc + 4;
                m_valid = 1;
                m_pc    = m_pc + 4;
            end
        end
    endtask

    task automatic compare();
        check("valid", out_valid, m_valid);
        check("instr", out_inst, m_inst);
        check("halt", out_halt, m_halt);
        if (m_valid) check("pc", out_pc, m_opc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic load(input int a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a[7:0]; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        stall = 0; pc_src = 0; target = 0;
        m_reset();
        repeat (2) step();
        check("rst_pc", out_pc, 32'h0);
        check("rst_inst", out_inst, 32'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_halt", out_halt, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) load(i, $urandom() & 32'h7FFF_FFFF);
        load(1, 32'h2009_0007);
        load(20, 32'hFFFF_FFFF);
        // Write word 0 in the same cycle as start: must be visible to the first fetch
        wr_en = 1; wr_addr = 0; wr_data = 32'h2008_0005; start = 1;
        step();
        wr_en = 0; start = 0;
        check("idle_before_first", out_valid, 1'b0);

        step();
        check("load0_inst", out_inst, 32'h2008_0005);
        check("load0_pc", out_pc, 32'd4);
        check("load0_valid", out_valid, 1'b1);
        step();
        check("load1_inst", out_inst, 32'h2009_0007);
        check("load1_pc", out_pc, 32'd8);
        step();
        check("pc8_opc", out_pc, 32'd12);

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", out_pc, 32'd12);
            check("stall_valid", out_valid, 1'b1);
        end
        stall = 0;
        step();
        check("post_stall_pc", out_pc, 32'd16);

        pc_src = 1; target = 32'h40; stall = 1;
        step();
        check("br_bubble", out_valid, 1'b0);
        pc_src = 0; stall = 0;
        step();
        check("br_pc", out_pc, 32'h44);
        check("br_inst", out_inst, m_mem[16]);

        repeat (3) step();
        stall = 1;
        step();
        check("halt_stalled", out_halt, 1'b0);
        stall = 0; pc_src = 1; target = 32'h100;
        step();
        check("halt_flushed", out_halt, 1'b0);
        pc_src = 0;
        step();
        check("hf_pc", out_pc, 32'h104);
        check("hf_halt", out_halt, 1'b0);

        pc_src = 1; target = 32'hFFFF_FFFC;
        step();
        pc_src = 0;
        step();
        check("wrap_pc", out_pc, 32'h0);
        check("wrap_inst", out_inst, m_mem[255]);
        step();
        check("wrap_next_pc", out_pc, 32'd4);
        check("wrap_next_inst", out_inst, 32'h2008_0005);

        #2 rst = 1'b1;
        #1;
        check("async_pc", out_pc, 32'h0);
        check("async_inst", out_inst, 32'h0);
        check("async_valid", out_valid, 1'b0);
        check("async_halt", out_halt, 1'b0);
        m_reset();
        #1 rst = 1'b0;

        load(3, 32'hFFFF_FFFF);
        start = 1;
        step();
        start = 0;
        repeat (3) step();
        check("pre_halt_pc", out_pc, 32'd12);
        step();
        check("halt_flag", out_halt, 1'b1);
        check("halt_valid", out_valid, 1'b0);
        wr_en = 1; wr_addr = 0; wr_data = 32'hDEAD_BEEF; stall = 0; pc_src = 1; target = 32'h80;
        repeat (3) step();
        wr_en = 0; pc_src = 0;
        check("halt_sticky", out_halt, 1'b1);

        rst = 1; step(); rst = 0;
        start = 1; step(); start = 0;
        step();
        check("rerun_inst", out_inst, 32'h2008_0005);
        check("rerun_pc", out_pc, 32'd4);

        for (int r = 0; r < 6; r++) begin
            rst = 1; step(); rst = 0;
            load(3, $urandom() & 32'h7FFF_FFFF);
            for (int k = 0; k < 8; k++)
                load($urandom_range(0, DEPTH - 1),
                     ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom());
            start = 1; step(); start = 0;
            for (int c = 0; c < 150; c++) begin
                stall   = ($urandom_range(0, 3) == 0);
                pc_src  = ($urandom_range(0, 9) == 0);
                target  = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                      : ($urandom_range(0, 1023) << 2);
                wr_en   = ($urandom_range(0, 7) == 0);
                wr_addr = 8'($urandom());
                wr_data = $urandom();
                start   = ($urandom_range(0, 15) == 0);
                step();
            end
            stall = 0; pc_src = 0; wr_en = 0; start = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
